test_pattern_gen: RTL
=====================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter DATA_W, default 14, sets the output sample width.
REQ-002 Parameter LFSR_W, default 9, sets the LFSR state width; SHALL satisfy 2 <= LFSR_W <= DATA_W.
REQ-003 Parameter TAPS, default 9'h110, is the LFSR feedback mask (x^9+x^5+1).
REQ-004 Parameter SEED, default 9'h1FF, is the LFSR reset/recovery value; SHALL be nonzero.
REQ-005 Parameter NOISE_MAX, default 4, sets the pulse-mode baseline counter ceiling.
REQ-006 CLOCK_IN  in  1  clock; all state updates on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 ENABLE  in  1  a sample is produced on each rising edge where ENABLE=1.
REQ-009 MODE  in  2  pattern select: 0 counter, 1 LFSR, 2 pulse, 3 constant.
REQ-010 WRAP  in  DATA_W  counter-mode terminal value.
REQ-011 PERIOD  in  16  pulse-mode peak period in samples.
REQ-012 PEAK  in  DATA_W  pulse-mode peak value and constant-mode value.
REQ-013 DATA  out  DATA_W  registered sample.
REQ-014 DATA_VALID  out  1  registered; high for one cycle per new sample.

Function
REQ-015 Registered mode mode_q SHALL be compared with MODE on every cycle where ENABLE=1.
REQ-016 ENABLE=1 and MODE != mode_q: mode_q <= MODE; count, noise, sample counters <= 0; LFSR <= SEED; DATA holds; DATA_VALID <= 0.
REQ-017 ENABLE=1 and MODE == mode_q: one sample per cycle per REQ-019..REQ-024; DATA_VALID <= 1; latency one cycle from the enabled edge.
REQ-018 ENABLE=0: all state and DATA hold; DATA_VALID <= 0; MODE changes are ignored until ENABLE=1.
REQ-019 Counter mode: DATA <= count (zero-extended); count <= 0 if count >= WRAP, else count+1.
REQ-020 Counter mode, WRAP=0: DATA SHALL be 0 on every sample.
REQ-021 Counter mode, WRAP lowered below count: the next sample outputs the current count, then count wraps to 0.
REQ-022 LFSR mode: DATA <= zero-extended state; state <= {state[LFSR_W-2:0], XOR-reduce(state & TAPS)}.
REQ-023 LFSR mode, all-zero state: state SHALL reload SEED on the next sample.
REQ-024 Pulse mode, PERIOD >= 1: if sample == PERIOD-1, DATA <= PEAK, sample <= 0 and noise <= 0.
REQ-025 Pulse mode, otherwise: DATA <= noise; noise <= 0 if noise >= NOISE_MAX, else noise+1; sample <= sample+1.
REQ-026 Pulse mode, PERIOD=0: no peak is ever output; noise counts as in REQ-025 and sample holds 0.
REQ-027 Constant mode: DATA <= PEAK on every sample.
REQ-028 Width rule: the LFSR occupies DATA[LFSR_W-1:0] and the upper bits are 0; the pulse-mode noise counter is DATA_W wide.

Reset
REQ-029 RESET=1 SHALL force DATA=0, DATA_VALID=0, mode_q=0, all counters 0, and LFSR=SEED on the next edge.
REQ-030 RESET SHALL take priority over ENABLE and MODE, including mid-sequence.
REQ-031 The first enabled cycle after reset with MODE=0 SHALL output DATA=0 and DATA_VALID=1.

Verification
REQ-032 Reset, MODE=0, WRAP=3, ENABLE=1 for 6 cycles -> DATA 0,1,2,3,0,1, DATA_VALID=1 throughout.
REQ-033 Defaults, MODE=1 (first enabled cycle is the mode change, DATA_VALID=0) -> DATA 0x1FF, 0x1FE, ...; 0x1FF recurs after exactly 511 valid samples.
REQ-034 MODE=2, PERIOD=8, PEAK=511 after mode change -> DATA 0,1,2,3,4,0,1,511,0,1.
REQ-035 Counter mid-run at count=2, MODE switched to 3 with PEAK=0x2AA -> one cycle DATA_VALID=0 with DATA held at 1, then DATA=0x2AA and DATA_VALID=1.
REQ-036 ENABLE toggled 1,0,1 in counter mode -> DATA holds and DATA_VALID=0 in the idle cycle; the sequence resumes unbroken.
REQ-037 RESET asserted mid-LFSR run -> next cycle DATA=0, DATA_VALID=0; after re-enable in MODE=1, the sequence restarts at 0x1FF.

Source files
------------

// File: rtl/test_pattern_gen.sv
// Test pattern generator: counter, LFSR, pulse-train and constant sample sources
// selected by MODE. One registered sample per enabled clock; a mode change spends
// one enabled cycle re-initialising the pattern state with DATA held and DATA_VALID low.
//
// state (mode_q) | meaning
// MODE_CNT       | ramp 0..WRAP, then back to 0
// MODE_LFSR      | Fibonacci LFSR state, zero-extended onto DATA
// MODE_PULSE     | small noise ramp 0..NOISE_MAX with a PEAK sample every PERIOD samples
// MODE_CONST     | PEAK on every sample
module test_pattern_gen #(
  parameter int                DATA_W    = 14,
  parameter int                LFSR_W    = 9,
  parameter logic [LFSR_W-1:0] TAPS      = 'h110,
  parameter logic [LFSR_W-1:0] SEED      = 'h1FF,
  parameter int                NOISE_MAX = 4
) (
  input  logic              CLOCK_IN,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [1:0]        MODE,
  input  logic [DATA_W-1:0] WRAP,
  input  logic [15:0]       PERIOD,
  input  logic [DATA_W-1:0] PEAK,
  output logic [DATA_W-1:0] DATA,
  output logic              DATA_VALID
);

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_PULSE = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  localparam logic [DATA_W-1:0] NOISE_CEIL = DATA_W'(NOISE_MAX);

  mode_e             mode_q,   mode_d;
  logic [DATA_W-1:0] count_q,  count_d;
  logic [DATA_W-1:0] noise_q,  noise_d;
  logic [15:0]       sample_q, sample_d;
  logic [LFSR_W-1:0] lfsr_q,   lfsr_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              lfsr_fb;

  // Register all pattern state; synchronous reset wins over everything else.
  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      mode_q     <= MODE_CNT;
      count_q    <= '0;
      noise_q    <= '0;
      sample_q   <= '0;
      lfsr_q     <= SEED;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      count_q    <= count_d;
      noise_q    <= noise_d;
      sample_q   <= sample_d;
      lfsr_q     <= lfsr_d;
      DATA       <= data_d;
      DATA_VALID <= valid_d;
    end
  end

  // Next-state and next-sample selection; everything holds unless enabled.
  always_comb begin
    mode_d   = mode_q;
    count_d  = count_q;
    noise_d  = noise_q;
    sample_d = sample_q;
    lfsr_d   = lfsr_q;
    data_d   = DATA;
    valid_d  = 1'b0;
    lfsr_fb  = ^(lfsr_q & TAPS);

    if (ENABLE) begin
      if (MODE != mode_q) begin
        // Mode change: restart the new pattern cleanly, no sample this cycle.
        mode_d   = mode_e'(MODE);
        count_d  = '0;
        noise_d  = '0;
        sample_d = '0;
        lfsr_d   = SEED;
      end else begin
        valid_d = 1'b1;
        unique case (mode_q)
          MODE_CNT: begin
            data_d  = count_q;
            // >= so that lowering WRAP below the running count still wraps.
            count_d = (count_q >= WRAP) ? '0 : count_q + 1'b1;
          end
          MODE_LFSR: begin
            data_d = DATA_W'(lfsr_q);
            // The all-zero state is a lock-up point; recover to SEED.
            if (lfsr_q == '0) lfsr_d = SEED;
            else              lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
          end
          MODE_PULSE: begin
            if ((PERIOD != 16'd0) && (sample_q == PERIOD - 16'd1)) begin
              data_d   = PEAK;
              sample_d = '0;
              noise_d  = '0;
            end else begin
              data_d   = noise_q;
              noise_d  = (noise_q >= NOISE_CEIL) ? '0 : noise_q + 1'b1;
              // With PERIOD=0 there is no peak, so the position is pinned at 0.
              sample_d = (PERIOD == 16'd0) ? 16'd0 : sample_q + 16'd1;
            end
          end
          MODE_CONST: begin
            data_d = PEAK;
          end
          default: begin
            data_d = DATA;
          end
        endcase
      end
    end
  end

endmodule
